// File: rtl/axi_dma_pkg.sv
// Shared encodings, state type and helpers for the AXI burst address generator.
// Imported by axi_beat_step and axi_burst_addr_gen.
package axi_dma_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam int PAGE_BITS = 12;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  function automatic logic [7:0] size_bytes(input logic [2:0] size);
    return 8'd1 << size;
  endfunction

endpackage

// File: rtl/axi_beat_step.sv
// Next beat address for FIXED/INCR/WRAP bursts.
// Upper bits above the 4 KB page are always taken from the burst base.
module axi_beat_step
  import axi_dma_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] i_base,
  input  logic [AW-1:0] i_cur,
  input  logic [2:0]    i_size,
  input  logic [7:0]    i_len,
  input  logic [1:0]    i_burst,
  output logic [AW-1:0] o_next
);

  localparam logic [AW-1:0] ONE = AW'(1);

  logic [AW-1:0] step;
  logic [AW-1:0] aligned;
  logic [AW-1:0] sum;
  logic [AW-1:0] wmask;
  logic [AW-1:0] raw;

  // align, advance one transfer, apply wrap window and page hold
  always_comb begin
    step    = AW'(size_bytes(i_size));
    aligned = i_cur & ~(step - ONE);
    sum     = aligned + step;
    wmask   = ((AW'(i_len) + ONE) << i_size) - ONE;
    unique case (i_burst)
      BURST_INCR: raw = sum;
      BURST_WRAP: raw = (sum & wmask) | (i_base & ~wmask);
      default:    raw = i_cur;
    endcase
    o_next = {i_base[AW-1:PAGE_BITS], raw[PAGE_BITS-1:0]};
  end

endmodule

// File: rtl/axi_burst_addr_gen.sv
// AXI4 burst address generator: one command in, one address per beat out.
// Optional byte strobes when AXI_BURST_STRB_EN is defined.
module axi_burst_addr_gen
  import axi_dma_pkg::*;
#(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int MAXLEN = 256
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_cmd_valid,
  output logic          o_cmd_ready,
  input  logic [AW-1:0] i_cmd_addr,
  input  logic [7:0]    i_cmd_len,
  input  logic [2:0]    i_cmd_size,
  input  logic [1:0]    i_cmd_burst,
  output logic          o_cmd_err,
  output logic          o_beat_valid,
  input  logic          i_beat_ready,
  output logic [AW-1:0] o_beat_addr,
  output logic [7:0]    o_beat_idx,
  output logic          o_beat_last,
`ifdef AXI_BURST_STRB_EN
  output logic [DW/8-1:0] o_beat_strb,
`endif
  output logic          o_busy
);

  localparam int NB       = DW / 8;
  localparam int MAX_SIZE = $clog2(NB);
  localparam logic [AW-1:0] ONE = AW'(1);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] base_q, base_d;
  logic [7:0]    len_q, len_d;
  logic [2:0]    size_q, size_d;
  logic [1:0]    burst_q, burst_d;
  logic [7:0]    idx_q, idx_d;
  logic          err_q, err_d;

  logic [AW-1:0] next_addr;
  logic          run;
  logic          last;
  logic          beat_hs;
  logic          accept;
  logic          legal;
  logic          wrap_len_ok;
  logic          align_ok;
  logic          len_ok;

  axi_beat_step #(.AW(AW)) u_step (
    .i_base  (base_q),
    .i_cur   (addr_q),
    .i_size  (size_q),
    .i_len   (len_q),
    .i_burst (burst_q),
    .o_next  (next_addr)
  );

  // handshake and command legality
  always_comb begin
    run         = (state_q == RUN);
    last        = run & (idx_q == len_q);
    beat_hs     = run & i_beat_ready;
    o_cmd_ready = (state_q == IDLE) | (beat_hs & last);
    accept      = i_cmd_valid & o_cmd_ready;
    wrap_len_ok = (i_cmd_len == 8'd1) || (i_cmd_len == 8'd3) ||
                  (i_cmd_len == 8'd7) || (i_cmd_len == 8'd15);
    align_ok    = (i_cmd_addr &
                   (AW'(size_bytes(i_cmd_size)) - ONE)) == '0;
    len_ok      = (32'(i_cmd_len) + 32'd1) <= 32'(MAXLEN);
    legal       = (i_cmd_size <= 3'(MAX_SIZE)) &&
                  (i_cmd_burst != 2'b11) &&
                  !((i_cmd_burst == BURST_WRAP) &&
                    (!wrap_len_ok || !align_ok)) &&
                  len_ok;
  end

  // burst FSM: beat advance, completion, command load
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    base_d  = base_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: ;
      RUN: begin
        if (beat_hs) begin
          if (last) begin
            state_d = IDLE;
          end else begin
            idx_d  = idx_q + 8'd1;
            addr_d = next_addr;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      if (legal) begin
        state_d = RUN;
        addr_d  = i_cmd_addr;
        base_d  = i_cmd_addr;
        len_d   = i_cmd_len;
        size_d  = i_cmd_size;
        burst_d = i_cmd_burst;
        idx_d   = 8'd0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // state and beat registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      base_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      base_q  <= base_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

`ifdef AXI_BURST_STRB_EN
  logic [NB-1:0] strb_q, strb_d;

  function automatic logic [NB-1:0] lane_mask(
    input logic [AW-1:0] a,
    input logic [2:0]    sz
  );
    logic [AW-1:0] sb;
    logic [AW-1:0] lo;
    logic [AW-1:0] hi;
    logic [NB-1:0] m;
    sb = AW'(size_bytes(sz));
    lo = a & AW'(NB - 1);
    hi = ((a & ~(sb - ONE)) + sb - ONE) & AW'(NB - 1);
    for (int i = 0; i < NB; i++) begin
      m[i] = (AW'(i) >= lo) && (AW'(i) <= hi);
    end
    return m;
  endfunction

  // strobe tracks the address register, zero when no beat is offered
  always_comb begin
    strb_d = '0;
    if (state_d == RUN) begin
      strb_d = lane_mask(addr_d, size_d);
    end
  end

  // strobe register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      strb_q <= '0;
    end else begin
      strb_q <= strb_d;
    end
  end

  assign o_beat_strb = strb_q;
`endif

  assign o_cmd_err    = err_q;
  assign o_beat_valid = run;
  assign o_beat_addr  = addr_q;
  assign o_beat_idx   = idx_q;
  assign o_beat_last  = last;
  assign o_busy       = run;

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Scoreboard bench for axi_burst_addr_gen: directed bursts, errors,
// back-to-back stall and mid-burst reset.
module tb_axi_burst_addr_gen;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic [AW-1:0] i_cmd_addr;
  logic [7:0]    i_cmd_len;
  logic [2:0]    i_cmd_size;
  logic [1:0]    i_cmd_burst;
  logic          o_cmd_err;
  logic          o_beat_valid;
  logic          i_beat_ready;
  logic [AW-1:0] o_beat_addr;
  logic [7:0]    o_beat_idx;
  logic          o_beat_last;
  logic          o_busy;
`ifdef AXI_BURST_STRB_EN
  logic [DW/8-1:0] o_beat_strb;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  idx;
    logic        last;
    logic [3:0]  strb;
  } beat_t;

  beat_t exp_q[$];
  int checks   = 0;
  int failures = 0;
  int err_exp  = 0;
  int err_seen = 0;

  axi_burst_addr_gen #(.AW(AW), .DW(DW), .MAXLEN(16)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_cmd_valid  (i_cmd_valid),
    .o_cmd_ready  (o_cmd_ready),
    .i_cmd_addr   (i_cmd_addr),
    .i_cmd_len    (i_cmd_len),
    .i_cmd_size   (i_cmd_size),
    .i_cmd_burst  (i_cmd_burst),
    .o_cmd_err    (o_cmd_err),
    .o_beat_valid (o_beat_valid),
    .i_beat_ready (i_beat_ready),
    .o_beat_addr  (o_beat_addr),
    .o_beat_idx   (o_beat_idx),
    .o_beat_last  (o_beat_last),
`ifdef AXI_BURST_STRB_EN
    .o_beat_strb  (o_beat_strb),
`endif
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  function automatic void chk(string name, logic [63:0] act,
                              logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  task automatic push(logic [31:0] a, logic [7:0] i, logic l,
                      logic [3:0] s);
    beat_t b;
    b.addr = a;
    b.idx  = i;
    b.last = l;
    b.strb = s;
    exp_q.push_back(b);
  endtask

  // monitor: compare every offered beat against the queue head
  always @(negedge i_clk) begin
    if (!i_reset && o_cmd_err) err_seen++;
    if (!i_reset && o_beat_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat actual=%0h required=none",
                 o_beat_addr);
      end else begin
        chk("beat_addr", 64'(o_beat_addr), 64'(exp_q[0].addr));
        chk("beat_idx", 64'(o_beat_idx), 64'(exp_q[0].idx));
        chk("beat_last", 64'(o_beat_last), 64'(exp_q[0].last));
`ifdef AXI_BURST_STRB_EN
        chk("beat_strb", 64'(o_beat_strb), 64'(exp_q[0].strb));
`endif
        if (i_beat_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic send(logic [31:0] a, logic [7:0] l, logic [2:0] s,
                      logic [1:0] b);
    int n = 0;
    i_cmd_valid = 1'b1;
    i_cmd_addr  = a;
    i_cmd_len   = l;
    i_cmd_size  = s;
    i_cmd_burst = b;
    while (!o_cmd_ready && n < 200) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL cmd_ready_timeout actual=0 required=1");
    end
    @(posedge i_clk); #1;
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || o_busy) && n < 200) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic bad_cmd(string name, logic [31:0] a, logic [7:0] l,
                         logic [2:0] s, logic [1:0] b);
    err_exp++;
    send(a, l, s, b);
    @(negedge i_clk);
    chk({name, "_err"}, 64'(o_cmd_err), 64'd1);
    @(negedge i_clk);
    chk({name, "_err_clr"}, 64'(o_cmd_err), 64'd0);
    chk({name, "_busy"}, 64'(o_busy), 64'd0);
    @(posedge i_clk); #1;
  endtask

  initial begin
    i_reset      = 1'b1;
    i_cmd_valid  = 1'b0;
    i_cmd_addr   = '0;
    i_cmd_len    = '0;
    i_cmd_size   = '0;
    i_cmd_burst  = '0;
    i_beat_ready = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    @(negedge i_clk);
    chk("rst_ready", 64'(o_cmd_ready), 64'd1);
    chk("rst_err", 64'(o_cmd_err), 64'd0);
    chk("rst_valid", 64'(o_beat_valid), 64'd0);
    chk("rst_addr", 64'(o_beat_addr), 64'd0);
    chk("rst_idx", 64'(o_beat_idx), 64'd0);
    chk("rst_last", 64'(o_beat_last), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    @(posedge i_clk); #1;

    // INCR aligned
    push(32'h1000, 8'd0, 1'b0, 4'b1111);
    push(32'h1004, 8'd1, 1'b0, 4'b1111);
    push(32'h1008, 8'd2, 1'b0, 4'b1111);
    push(32'h100C, 8'd3, 1'b1, 4'b1111);
    send(32'h1000, 8'd3, 3'd2, 2'b01);
    @(negedge i_clk);
    chk("incr_busy", 64'(o_busy), 64'd1);
    chk("incr_ready_mid", 64'(o_cmd_ready), 64'd0);
    wait_idle();

    // WRAP within 16-byte window
    push(32'h2038, 8'd0, 1'b0, 4'b1111);
    push(32'h203C, 8'd1, 1'b0, 4'b1111);
    push(32'h2030, 8'd2, 1'b0, 4'b1111);
    push(32'h2034, 8'd3, 1'b1, 4'b1111);
    send(32'h2038, 8'd3, 3'd2, 2'b10);
    wait_idle();

    // INCR held within the first 4 KB page
    push(32'h0FFC, 8'd0, 1'b0, 4'b1111);
    push(32'h0000, 8'd1, 1'b0, 4'b1111);
    push(32'h0004, 8'd2, 1'b0, 4'b1111);
    push(32'h0008, 8'd3, 1'b1, 4'b1111);
    send(32'h0FFC, 8'd3, 3'd2, 2'b01);
    wait_idle();

    // FIXED
    push(32'h0040, 8'd0, 1'b0, 4'b1111);
    push(32'h0040, 8'd1, 1'b0, 4'b1111);
    push(32'h0040, 8'd2, 1'b1, 4'b1111);
    send(32'h0040, 8'd2, 3'd2, 2'b00);
    wait_idle();

    // unaligned first beat
    push(32'h1003, 8'd0, 1'b0, 4'b1000);
    push(32'h1004, 8'd1, 1'b1, 4'b1111);
    send(32'h1003, 8'd1, 3'd2, 2'b01);
    wait_idle();

    // len=0 single beat, byte size
    push(32'h0105, 8'd0, 1'b1, 4'b0010);
    send(32'h0105, 8'd0, 3'd0, 2'b01);
    wait_idle();

    // maximum legal length (MAXLEN=16), byte transfers
    for (int i = 0; i < 16; i++) begin
      push(32'h3000 + 32'(i), 8'(i), (i == 15),
           4'(1 << (i % 4)));
    end
    send(32'h3000, 8'd15, 3'd0, 2'b01);
    wait_idle();

    // rejected commands
    bad_cmd("wrap_unaligned", 32'h2039, 8'd3, 3'd2, 2'b10);
    bad_cmd("burst_rsvd", 32'h1000, 8'd3, 3'd2, 2'b11);
    bad_cmd("size_big", 32'h1000, 8'd1, 3'd3, 2'b01);
    bad_cmd("wrap_len2", 32'h1000, 8'd2, 3'd2, 2'b10);
    bad_cmd("len_over", 32'h1000, 8'd16, 3'd0, 2'b01);

    // back-to-back with a stall on the last beat
    push(32'h0100, 8'd0, 1'b0, 4'b1111);
    push(32'h0104, 8'd1, 1'b1, 4'b1111);
    push(32'h0200, 8'd0, 1'b0, 4'b1111);
    push(32'h0204, 8'd1, 1'b1, 4'b1111);
    send(32'h0100, 8'd1, 3'd2, 2'b01);
    i_cmd_valid = 1'b1;
    i_cmd_addr  = 32'h0200;
    i_cmd_len   = 8'd1;
    i_cmd_size  = 3'd2;
    i_cmd_burst = 2'b01;
    @(posedge i_clk); #1;
    i_beat_ready = 1'b0;
    @(negedge i_clk);
    chk("b2b_stall_ready", 64'(o_cmd_ready), 64'd0);
    @(posedge i_clk); #1;
    i_beat_ready = 1'b1;
    @(negedge i_clk);
    chk("b2b_last_ready", 64'(o_cmd_ready), 64'd1);
    @(posedge i_clk); #1;
    i_cmd_valid = 1'b0;
    @(negedge i_clk);
    chk("b2b_no_bubble", 64'(o_beat_valid), 64'd1);
    wait_idle();

    // reset while idx 2 of an 8-beat burst is offered
    push(32'h5000, 8'd0, 1'b0, 4'b1111);
    push(32'h5004, 8'd1, 1'b0, 4'b1111);
    send(32'h5000, 8'd7, 3'd2, 2'b01);
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    @(negedge i_clk);
    chk("mrst_valid", 64'(o_beat_valid), 64'd0);
    chk("mrst_ready", 64'(o_cmd_ready), 64'd1);
    chk("mrst_addr", 64'(o_beat_addr), 64'd0);
    chk("mrst_idx", 64'(o_beat_idx), 64'd0);
    chk("mrst_last", 64'(o_beat_last), 64'd0);
    chk("mrst_busy", 64'(o_busy), 64'd0);
    chk("mrst_err", 64'(o_cmd_err), 64'd0);
    chk("mrst_drained", 64'(exp_q.size()), 64'd0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("post_rst_valid", 64'(o_beat_valid), 64'd0);
    chk("err_pulses", 64'(err_seen), 64'(err_exp));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
